// File: rtl/vmem_scheduler.sv
// vmem_scheduler: arbitrates the single-port frame buffer between display
// scan-out reads (highest priority), a hardware clear engine and a small
// FIFO of host pixel writes that drains on cycles the display leaves idle.
module vmem_scheduler #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 disp_rd_en,
  input  logic [9:0]                           disp_h,
  input  logic [8:0]                           disp_v,
  output logic [23:0]                          disp_data,
  output logic                                 disp_data_valid,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  input  logic [18:0]                          wr_addr,
  input  logic [23:0]                          wr_data,
  input  logic                                 clr_start,
  input  logic [23:0]                          clr_color,
  output logic                                 clr_busy,
  output logic [$clog2(FIFO_DEPTH):0]          fifo_count,
  output logic                                 mem_en,
  output logic                                 mem_we,
  output logic [18:0]                          mem_addr,
  output logic [23:0]                          mem_wdata,
  input  logic [23:0]                          mem_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [9:0] H_LAST = 10'(H_RES - 1);
  localparam logic [8:0] V_LAST = 9'(V_RES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state, state_next;
  logic [9:0]         h_cnt;
  logic [8:0]         v_cnt;
  logic [23:0]        clr_color_q;
  logic [18:0]        fifo_addr [FIFO_DEPTH];
  logic [23:0]        fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               rd_d1;
  logic               full, empty, push, pop;
  logic               clr_accept, clr_write, clr_last;

  assign full       = (count == CNT_FULL);
  assign empty      = (count == '0);
  assign clr_accept = (state == IDLE) && clr_start && empty;
  assign clr_write  = (state == CLEAR) && !disp_rd_en;
  assign clr_last   = clr_write && (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign push       = wr_valid && wr_ready;
  assign pop        = !disp_rd_en && (state != CLEAR) && !empty;
  assign fifo_count = count;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: a clear starts only with an empty FIFO and ends on its last pixel
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clr_accept) state_next = CLEAR;
      CLEAR:   if (clr_last)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory port and handshake outputs: display read, then clear, then FIFO
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wr_ready  = (state == IDLE) && !full && !(clr_start && empty);
    clr_busy  = (state == CLEAR);
    if (disp_rd_en) begin
      mem_en   = 1'b1;
      mem_addr = {disp_h, disp_v};
    end else if (state == CLEAR) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = {h_cnt, v_cnt};
      mem_wdata = clr_color_q;
    end else if (!empty) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = fifo_addr[rd_ptr];
      mem_wdata = fifo_data[rd_ptr];
    end
  end

  // Clear engine: latch colour at start, walk columns of rows v-first, stall on display reads
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      clr_color_q <= '0;
    end else if (clr_accept) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      clr_color_q <= clr_color;
    end else if (clr_write) begin
      if (v_cnt == V_LAST) begin
        v_cnt <= '0;
        h_cnt <= h_cnt + 10'd1;
      end else begin
        v_cnt <= v_cnt + 9'd1;
      end
    end
  end

  // Write FIFO pointers and occupancy; simultaneous push and pop keep the count
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage needs no reset; occupancy decides what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  // Display return path: memory answers one cycle later, registered one more
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_d1           <= 1'b0;
      disp_data_valid <= 1'b0;
      disp_data       <= '0;
    end else begin
      rd_d1           <= disp_rd_en;
      disp_data_valid <= rd_d1;
      if (rd_d1) disp_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vmem_scheduler.sv
// tb_vmem_scheduler: directed test of vmem_scheduler with a small 4x2 clear
// area and a behavioural one-cycle-latency frame memory.
module tb_vmem_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_rd_en;
  logic [9:0]  disp_h;
  logic [8:0]  disp_v;
  logic [23:0] disp_data;
  logic        disp_data_valid;
  logic        wr_valid;
  logic        wr_ready;
  logic [18:0] wr_addr;
  logic [23:0] wr_data;
  logic        clr_start;
  logic [23:0] clr_color;
  logic        clr_busy;
  logic [2:0]  fifo_count;
  logic        mem_en;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [23:0] fmem [int];

  vmem_scheduler #(.H_RES(4), .V_RES(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .disp_rd_en(disp_rd_en), .disp_h(disp_h), .disp_v(disp_v),
    .disp_data(disp_data), .disp_data_valid(disp_data_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
    .fifo_count(fifo_count),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Frame memory model: synchronous write, read data one cycle after the access
  always @(posedge clk) begin
    if (mem_en && mem_we) fmem[int'(mem_addr)] = mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= fmem.exists(int'(mem_addr)) ? fmem[int'(mem_addr)] : 24'h0;
  end

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance to the next cycle's drive point (falling edge)
  task automatic applyStimulus();
    @(negedge clk);
  endtask

  function automatic logic [18:0] hv(input int h, input int v);
    return {10'(h), 9'(v)};
  endfunction

  logic [18:0] clrOrder [8];
  logic [18:0] qAddr [4];
  logic [23:0] qData [4];

  initial begin
    int k;
    for (int h = 0; h < 4; h++)
      for (int v = 0; v < 2; v++)
        clrOrder[h*2+v] = hv(h, v);
    qAddr[0] = 19'h00101; qData[0] = 24'hA00001;
    qAddr[1] = 19'h7FFFF; qData[1] = 24'hA00002;
    qAddr[2] = 19'h00002; qData[2] = 24'hA00003;
    qAddr[3] = 19'h12345; qData[3] = 24'hA00004;

    rst = 1'b1; disp_rd_en = 0; disp_h = 0; disp_v = 0;
    wr_valid = 0; wr_addr = 0; wr_data = 0; clr_start = 0; clr_color = 0;
    mem_rdata = 0;

    // Reset for two cycles
    applyStimulus(); applyStimulus();
    rst = 1'b0;
    #1;
    checkOutput("rst_mem_en", 32'(mem_en), 0);
    checkOutput("rst_clr_busy", 32'(clr_busy), 0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 0);
    checkOutput("rst_disp_valid", 32'(disp_data_valid), 0);
    checkOutput("rst_wr_ready", 32'(wr_ready), 1);

    // Display latency
    fmem[int'(hv(5, 7))] = 24'h123456;
    applyStimulus();
    disp_rd_en = 1; disp_h = 10'd5; disp_v = 9'd7;
    #1;
    checkOutput("disp_addr", 32'(mem_addr), 32'h00A07);
    checkOutput("disp_en", 32'(mem_en), 1);
    checkOutput("disp_we", 32'(mem_we), 0);
    applyStimulus();
    disp_rd_en = 0;
    #1;
    checkOutput("disp_valid_n1", 32'(disp_data_valid), 0);
    applyStimulus();
    #1;
    checkOutput("disp_valid_n2", 32'(disp_data_valid), 1);
    checkOutput("disp_data_n2", 32'(disp_data), 32'h123456);
    applyStimulus();
    #1;
    checkOutput("disp_valid_n3", 32'(disp_data_valid), 0);
    checkOutput("disp_hold", 32'(disp_data), 32'h123456);

    // FIFO backpressure while display owns the port
    disp_rd_en = 1; disp_h = 0; disp_v = 0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1; wr_addr = (i < 4) ? qAddr[i] : 19'h55555; wr_data = (i < 4) ? qData[i] : 24'hBAD000;
      #1;
      checkOutput($sformatf("bp_ready_%0d", i), 32'(wr_ready), (i < 4) ? 1 : 0);
      checkOutput($sformatf("bp_count_%0d", i), 32'(fifo_count), (i < 4) ? i : 4);
      applyStimulus();
    end
    wr_valid = 0; disp_rd_en = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("drain_we_%0d", i), 32'(mem_we), 1);
      checkOutput($sformatf("drain_addr_%0d", i), 32'(mem_addr), 32'(qAddr[i]));
      checkOutput($sformatf("drain_data_%0d", i), 32'(mem_wdata), 32'(qData[i]));
      applyStimulus();
    end
    #1;
    checkOutput("drain_count", 32'(fifo_count), 0);
    checkOutput("drain_idle", 32'(mem_en), 0);

    // Priority: queued write deferred by a display read
    applyStimulus();
    wr_valid = 1; wr_addr = 19'h0ABCD; wr_data = 24'hC0FFEE;
    applyStimulus();
    wr_valid = 0; disp_rd_en = 1; disp_h = 10'd1; disp_v = 9'd1;
    #1;
    checkOutput("prio_rd_we", 32'(mem_we), 0);
    checkOutput("prio_rd_addr", 32'(mem_addr), 32'(hv(1, 1)));
    checkOutput("prio_count", 32'(fifo_count), 1);
    applyStimulus();
    disp_rd_en = 0;
    #1;
    checkOutput("prio_wr_we", 32'(mem_we), 1);
    checkOutput("prio_wr_addr", 32'(mem_addr), 32'h0ABCD);
    checkOutput("prio_wr_data", 32'(mem_wdata), 32'hC0FFEE);
    applyStimulus();
    #1;
    checkOutput("prio_empty", 32'(fifo_count), 0);

    // Clear without display reads: 8 cycles busy
    clr_start = 1; clr_color = 24'h00FF00;
    #1;
    checkOutput("clr_start_ready", 32'(wr_ready), 0);
    applyStimulus();
    clr_start = 0; clr_color = 24'h0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checkOutput($sformatf("clr_busy_%0d", i), 32'(clr_busy), 1);
      checkOutput($sformatf("clr_we_%0d", i), 32'(mem_we), 1);
      checkOutput($sformatf("clr_addr_%0d", i), 32'(mem_addr), 32'(clrOrder[i]));
      checkOutput($sformatf("clr_data_%0d", i), 32'(mem_wdata), 32'h00FF00);
      checkOutput($sformatf("clr_wr_ready_%0d", i), 32'(wr_ready), 0);
      applyStimulus();
    end
    #1;
    checkOutput("clr_done_busy", 32'(clr_busy), 0);
    checkOutput("clr_done_en", 32'(mem_en), 0);

    // Clear with three interleaved display reads: 11 cycles busy
    clr_start = 1; clr_color = 24'h0000AA;
    applyStimulus();
    clr_start = 0;
    k = 0;
    for (int j = 0; j < 11; j++) begin
      disp_rd_en = (j == 2 || j == 5 || j == 8);
      disp_h = 10'd9; disp_v = 9'd3;
      #1;
      checkOutput($sformatf("clr2_busy_%0d", j), 32'(clr_busy), 1);
      if (disp_rd_en) begin
        checkOutput($sformatf("clr2_rd_%0d", j), 32'({mem_en, mem_we}), 32'b10);
      end else begin
        checkOutput($sformatf("clr2_addr_%0d", j), 32'(mem_addr), 32'(clrOrder[k]));
        checkOutput($sformatf("clr2_data_%0d", j), 32'(mem_wdata), 32'h0000AA);
        k++;
      end
      applyStimulus();
    end
    disp_rd_en = 0;
    #1;
    checkOutput("clr2_done_busy", 32'(clr_busy), 0);
    checkOutput("clr2_pixels", 32'(k), 8);

    // Clear gating: clr_start with two queued writes is ignored
    applyStimulus();
    disp_rd_en = 1; disp_h = 0; disp_v = 0;
    wr_valid = 1; wr_addr = 19'h00011; wr_data = 24'h111111;
    applyStimulus();
    wr_addr = 19'h00022; wr_data = 24'h222222;
    applyStimulus();
    wr_valid = 0;
    #1;
    checkOutput("gate_count", 32'(fifo_count), 2);
    clr_start = 1; clr_color = 24'hFFFFFF;
    applyStimulus();
    clr_start = 0;
    #1;
    checkOutput("gate_busy", 32'(clr_busy), 0);
    disp_rd_en = 0;
    #1;
    checkOutput("gate_pop0", 32'(mem_addr), 32'h00011);
    applyStimulus();
    #1;
    checkOutput("gate_pop1", 32'(mem_addr), 32'h00022);
    applyStimulus();
    #1;
    checkOutput("gate_empty", 32'(fifo_count), 0);
    checkOutput("gate_busy_after", 32'(clr_busy), 0);

    // Reset during the third clear write
    clr_start = 1; clr_color = 24'h777777;
    applyStimulus();
    clr_start = 0;
    applyStimulus();
    applyStimulus();
    #1;
    checkOutput("mid_third_addr", 32'(mem_addr), 32'(clrOrder[2]));
    rst = 1;
    applyStimulus();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("mid_busy_%0d", i), 32'(clr_busy), 0);
      checkOutput($sformatf("mid_en_%0d", i), 32'(mem_en), 0);
      applyStimulus();
    end
    checkOutput("mid_wr_ready", 32'(wr_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
